// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target types, bus constants and status bit positions
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_LOAD,
        ST_TX_BYTE,
        ST_TX_ACK
    } i2c_slave_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

    // Bit positions inside status_o, also used by the initiator's status decode.
    localparam int STAT_ADDR_MATCH = 0;
    localparam int STAT_WR_ACTIVE  = 1;
    localparam int STAT_RD_ACTIVE  = 2;
    localparam int STAT_NACK_RCVD  = 3;
    localparam int STAT_STRETCHING = 4;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - two-flop synchroniser, glitch filter and edge pulses for one bus line
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_q;
    logic             fall_q;

    // Accept a new level only after FILT_LEN consecutive synchronised samples disagree with
    // the current one; the edge pulse is raised in the same cycle the level flips.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                rise_q  <= sync_q[1];
                fall_q  <= !sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: address match, write receive, read transmit with clock stretching
module i2c_slave
    import i2c_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FILT_LEN   = 3,
    localparam int ADDR_WIDTH = DATA_WIDTH - 1
) (
    input  logic                  clk_i,
    input  logic                  s_rst_n_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] own_addr_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [7:0]            status_o,
    output logic                  scl_o,
    input  logic                  scl_i,
    output logic                  scl_t,
    output logic                  sda_o,
    input  logic                  sda_i,
    output logic                  sda_t
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i   (clk_i),
        .rst_n_i (s_rst_n_i),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i   (clk_i),
        .rst_n_i (s_rst_n_i),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_slave_state_t      state_q;
    logic [2:0]            bit_cnt_q;
    logic [DATA_WIDTH-2:0] rx_shift_q;
    logic [DATA_WIDTH-2:0] tx_shift_q;
    logic [ADDR_WIDTH-1:0] own_addr_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_ready_q;
    logic                  scl_t_q;
    logic                  sda_t_q;
    logic                  ack_on_q;
    logic                  rw_q;
    logic                  match_q;
    logic                  wr_act_q;
    logic                  rd_act_q;
    logic                  nack_q;
    logic                  stretch_q;

    logic                  start_det;
    logic                  stop_det;
    logic [DATA_WIDTH-1:0] rx_byte_d;
    logic                  load_d;

    assign start_det = sda_fall && scl_lvl;
    assign stop_det  = sda_rise && scl_lvl;
    assign rx_byte_d = {rx_shift_q, sda_lvl};
    // Read data is taken either at the SCL fall closing the ACK slot or, once stretching, as soon as it shows up.
    assign load_d    = (state_q == ST_TX_LOAD) && tx_valid_i && (stretch_q || scl_fall);

    // Protocol FSM with registered pad enables, strobes and status flags.
    always_ff @(posedge clk_i or negedge s_rst_n_i) begin
        if (!s_rst_n_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            own_addr_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            scl_t_q    <= 1'b1;
            sda_t_q    <= 1'b1;
            ack_on_q   <= 1'b0;
            rw_q       <= I2C_RW_WRITE;
            match_q    <= 1'b0;
            wr_act_q   <= 1'b0;
            rd_act_q   <= 1'b0;
            nack_q     <= 1'b0;
            stretch_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            if (!en_i) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                scl_t_q   <= 1'b1;
                sda_t_q   <= 1'b1;
                ack_on_q  <= 1'b0;
                stretch_q <= 1'b0;
                match_q   <= 1'b0;
                wr_act_q  <= 1'b0;
                rd_act_q  <= 1'b0;
            end else if (start_det) begin
                state_q    <= ST_ADDR;
                bit_cnt_q  <= '0;
                own_addr_q <= own_addr_i;
                scl_t_q    <= 1'b1;
                sda_t_q    <= 1'b1;
                ack_on_q   <= 1'b0;
                stretch_q  <= 1'b0;
                match_q    <= 1'b0;
                wr_act_q   <= 1'b0;
                rd_act_q   <= 1'b0;
                nack_q     <= 1'b0;
            end else if (stop_det) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                scl_t_q   <= 1'b1;
                sda_t_q   <= 1'b1;
                ack_on_q  <= 1'b0;
                stretch_q <= 1'b0;
                match_q   <= 1'b0;
                wr_act_q  <= 1'b0;
                rd_act_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            rx_shift_q <= rx_byte_d[DATA_WIDTH-2:0];
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (rx_byte_d[DATA_WIDTH-1:1] == own_addr_q) begin
                                    state_q  <= ST_ADDR_ACK;
                                    ack_on_q <= 1'b0;
                                    rw_q     <= rx_byte_d[0];
                                    match_q  <= 1'b1;
                                    wr_act_q <= (rx_byte_d[0] == I2C_RW_WRITE);
                                    rd_act_q <= (rx_byte_d[0] == I2C_RW_READ);
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_RX_ACK: begin
                        // First fall starts the ACK slot, second fall ends it; reads leave at the ACK rise.
                        if (scl_fall) begin
                            if (!ack_on_q) begin
                                sda_t_q  <= I2C_ACK;
                                ack_on_q <= 1'b1;
                            end else if (state_q == ST_RX_ACK || rw_q == I2C_RW_WRITE) begin
                                sda_t_q   <= 1'b1;
                                ack_on_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= ST_RX_BYTE;
                            end
                        end else if (scl_rise && ack_on_q && state_q == ST_ADDR_ACK
                                     && rw_q == I2C_RW_READ) begin
                            ack_on_q  <= 1'b0;
                            stretch_q <= 1'b0;
                            state_q   <= ST_TX_LOAD;
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            rx_shift_q <= rx_byte_d[DATA_WIDTH-2:0];
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= rx_byte_d;
                                rx_valid_q <= 1'b1;
                                ack_on_q   <= 1'b0;
                                state_q    <= ST_RX_ACK;
                            end
                        end
                    end
                    ST_TX_LOAD: begin
                        if (load_d) begin
                            tx_shift_q <= tx_data_i[DATA_WIDTH-2:0];
                            sda_t_q    <= tx_data_i[DATA_WIDTH-1];
                            tx_ready_q <= 1'b1;
                            stretch_q  <= 1'b0;
                            bit_cnt_q  <= '0;
                            state_q    <= ST_TX_BYTE;
                        end else if (scl_fall) begin
                            sda_t_q   <= 1'b1;
                            scl_t_q   <= 1'b0;
                            stretch_q <= 1'b1;
                        end
                    end
                    ST_TX_BYTE: begin
                        // SCL is released one cycle after the MSB is on SDA, giving data setup time.
                        scl_t_q <= 1'b1;
                        if (scl_fall) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_t_q   <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= ST_TX_ACK;
                            end else begin
                                sda_t_q    <= tx_shift_q[DATA_WIDTH-2];
                                tx_shift_q <= {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
                                bit_cnt_q  <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == I2C_ACK) begin
                                stretch_q <= 1'b0;
                                state_q   <= ST_TX_LOAD;
                            end else begin
                                nack_q  <= 1'b1;
                                sda_t_q <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Status word assembled from the registered flags.
    always_comb begin
        status_o                  = '0;
        status_o[STAT_ADDR_MATCH] = match_q;
        status_o[STAT_WR_ACTIVE]  = wr_act_q;
        status_o[STAT_RD_ACTIVE]  = rd_act_q;
        status_o[STAT_NACK_RCVD]  = nack_q;
        status_o[STAT_STRETCHING] = stretch_q;
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = tx_ready_q;
    assign scl_o      = 1'b0;
    assign sda_o      = 1'b0;
    assign scl_t      = scl_t_q;
    assign sda_t      = sda_t_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave driving an open-drain bus model
module tb_i2c_slave;

    localparam int Q = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] own_addr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] status;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic       scl_m, sda_m;
    logic       scl_line, sda_line;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    logic [7:0] rx_prev = 8'h00;
    logic       overlap = 1'b0;

    always #5 clk = ~clk;

    assign scl_line = scl_m & (scl_t | scl_o);
    assign sda_line = sda_m & (sda_t | sda_o);

    i2c_slave #(.DATA_WIDTH(8), .FILT_LEN(8)) dut (
        .clk_i      (clk),
        .s_rst_n_i  (rst_n),
        .en_i       (en),
        .own_addr_i (own_addr),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .status_o   (status),
        .scl_o      (scl_o),
        .scl_i      (scl_line),
        .scl_t      (scl_t),
        .sda_o      (sda_o),
        .sda_i      (sda_line),
        .sda_t      (sda_t)
    );

    // Strobe monitor: counts pulses, keeps the last two received bytes.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rx_prev <= rx_last;
            rx_last <= rx_data;
        end
        if (tx_ready) tx_cnt <= tx_cnt + 1;
        if (rx_valid && tx_ready) overlap <= 1'b1;
    end

    initial begin
        #900us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_line !== 1'b1 && n < 10000) begin
            tick(1);
            n++;
        end
        if (scl_line !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout actual=0 required=1");
        end
    endtask

    task automatic wait_tx_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 20000) begin
            tick(1);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tx_ready_timeout actual=0 required=1");
        end
        tick(1);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; wait_scl_high(); tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; wait_scl_high(); tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic i2c_bit(input logic b, input logic glitch, output logic rb);
        sda_m = b; tick(Q);
        scl_m = 1'b1; wait_scl_high(); tick(Q / 2);
        if (glitch) begin
            sda_m = ~b; tick(5);
            sda_m = b;
        end
        tick(Q / 2);
        rb = sda_line;
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_byte(input logic [7:0] wb, input logic ack_drv, input logic [7:0] gmask,
                            output logic [7:0] rb, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(wb[i], gmask[i], b);
            rb[i] = b;
        end
        i2c_bit(ack_drv, 1'b0, ack);
    endtask

    typedef struct {
        logic [6:0] own;
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_status;
    } wr_vec_t;

    wr_vec_t    vt[7];
    int         rx0, tx0;
    logic [7:0] rb, rb2;
    logic       ack, ack2;
    logic [7:0] exp_rx;

    initial begin
        vt[0] = '{7'h50, 7'h50, 8'hA5, 1'b0, 8'h03};
        vt[1] = '{7'h50, 7'h51, 8'h11, 1'b1, 8'h00};
        vt[2] = '{7'h50, 7'h00, 8'h22, 1'b1, 8'h00};
        vt[3] = '{7'h00, 7'h00, 8'h5A, 1'b0, 8'h03};
        vt[4] = '{7'h7F, 7'h7F, 8'hFF, 1'b0, 8'h03};
        vt[5] = '{7'h2A, 7'h2A, 8'h00, 1'b0, 8'h03};
        vt[6] = '{7'h50, 7'h10, 8'h44, 1'b1, 8'h00};
        exp_rx = 8'h00;

        rst_n = 1'b0; en = 1'b1; own_addr = 7'h50;
        tx_data = 8'h00; tx_valid = 1'b0;
        scl_m = 1'b1; sda_m = 1'b1;
        tick(5);
        check("reset_lines", 32'({scl_t, sda_t}), 32'h3);
        check("reset_strobes", 32'({rx_valid, tx_ready}), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_status", 32'(status), 32'h00);
        rst_n = 1'b1;
        tick(20);

        // Table: single-byte writes with matching and non-matching addresses.
        for (int i = 0; i < 7; i++) begin
            own_addr = vt[i].own;
            rx0 = rx_cnt;
            i2c_start();
            i2c_byte({vt[i].addr, 1'b0}, 1'b1, 8'h00, rb, ack);
            check($sformatf("v%0d_addr_ack", i), 32'(ack), 32'(vt[i].exp_ack));
            check($sformatf("v%0d_status", i), 32'(status), 32'(vt[i].exp_status));
            i2c_byte(vt[i].data, 1'b1, 8'h00, rb, ack);
            check($sformatf("v%0d_data_ack", i), 32'(ack), 32'(vt[i].exp_ack));
            if (vt[i].exp_ack == 1'b0) exp_rx = vt[i].data;
            check($sformatf("v%0d_rx_count", i), 32'(rx_cnt - rx0), 32'(!vt[i].exp_ack));
            check($sformatf("v%0d_rx_data", i), 32'(rx_last), 32'(exp_rx));
            i2c_stop();
            tick(20);
            check($sformatf("v%0d_status_stop", i), 32'(status), 32'h00);
        end

        // Two-byte write.
        own_addr = 7'h50;
        rx0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, 1'b1, 8'h00, rb, ack);
        check("w2_addr_ack", 32'(ack), 32'h0);
        i2c_byte(8'hA5, 1'b1, 8'h00, rb, ack);
        check("w2_ack1", 32'(ack), 32'h0);
        i2c_byte(8'h3C, 1'b1, 8'h00, rb, ack);
        check("w2_ack2", 32'(ack), 32'h0);
        check("w2_status", 32'(status), 32'h03);
        i2c_stop();
        tick(20);
        check("w2_rx_count", 32'(rx_cnt - rx0), 32'h2);
        check("w2_rx_bytes", 32'({rx_prev, rx_last}), 32'hA53C);
        check("w2_status_stop", 32'(status), 32'h00);

        // Read with clock stretching until data is offered.
        tx0 = tx_cnt;
        tx_valid = 1'b0;
        i2c_start();
        i2c_byte(8'hA1, 1'b1, 8'h00, rb, ack);
        check("st_addr_ack", 32'(ack), 32'h0);
        check("st_status", 32'(status), 32'h15);
        fork
            begin
                i2c_byte(8'hFF, 1'b1, 8'h00, rb, ack);
            end
            begin
                tick(4000);
                check("st_scl_held", 32'(scl_line), 32'h0);
                check("st_status_hold", 32'(status), 32'h15);
                tx_data = 8'h96;
                tx_valid = 1'b1;
                wait_tx_ready();
                tx_valid = 1'b0;
            end
        join
        check("st_read_data", 32'(rb), 32'h96);
        check("st_tx_ready_count", 32'(tx_cnt - tx0), 32'h1);
        check("st_status_nack", 32'(status), 32'h0D);
        i2c_stop();
        tick(20);
        check("st_status_stop", 32'(status), 32'h08);

        // Two-byte read, master ACKs the first and NACKs the second.
        tx0 = tx_cnt;
        tx_data = 8'h11;
        tx_valid = 1'b1;
        fork
            begin
                i2c_start();
                i2c_byte(8'hA1, 1'b1, 8'h00, rb, ack);
                check("r2_addr_ack", 32'(ack), 32'h0);
                check("r2_status", 32'(status), 32'h05);
                i2c_byte(8'hFF, 1'b0, 8'h00, rb, ack);
                i2c_byte(8'hFF, 1'b1, 8'h00, rb2, ack2);
            end
            begin
                wait_tx_ready();
                tx_data = 8'h22;
                wait_tx_ready();
                tx_valid = 1'b0;
            end
        join
        check("r2_bytes", 32'({rb, rb2}), 32'h1122);
        check("r2_tx_ready_count", 32'(tx_cnt - tx0), 32'h2);
        check("r2_status_nack", 32'(status), 32'h0D);
        check("r2_sda_released", 32'(sda_t), 32'h1);
        i2c_stop();
        tick(20);

        // Write then repeated START into a read, no STOP in between.
        rx0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, 1'b1, 8'h00, rb, ack);
        check("rs_addr_ack", 32'(ack), 32'h0);
        i2c_byte(8'h12, 1'b1, 8'h00, rb, ack);
        check("rs_rx_data", 32'({rx_cnt - rx0, rx_last}), 32'h0112);
        tx_data = 8'h5C;
        tx_valid = 1'b1;
        i2c_start();
        i2c_byte(8'hA1, 1'b1, 8'h00, rb, ack);
        check("rs_read_ack", 32'(ack), 32'h0);
        check("rs_status", 32'(status), 32'h05);
        i2c_byte(8'hFF, 1'b1, 8'h00, rb, ack);
        tx_valid = 1'b0;
        check("rs_read_data", 32'(rb), 32'h5C);
        i2c_stop();
        tick(20);

        // STOP after four data bits.
        rx0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, 1'b1, 8'h00, rb, ack);
        for (int i = 0; i < 4; i++) i2c_bit(i[0], 1'b0, ack2);
        i2c_stop();
        tick(20);
        check("ps_status", 32'(status), 32'h00);
        check("ps_lines", 32'({scl_t, sda_t}), 32'h3);

        // Asynchronous reset while the target drives a read bit.
        tx_data = 8'h00;
        tx_valid = 1'b1;
        i2c_start();
        i2c_byte(8'hA1, 1'b1, 8'h00, rb, ack);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, 1'b0, ack2);
        tx_valid = 1'b0;
        check("rr_sda_driven", 32'(sda_t), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rr_lines_async", 32'({scl_t, sda_t}), 32'h3);
        check("rr_status", 32'(status), 32'h00);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        i2c_stop();
        tick(20);
        check("rr_no_rx", 32'(rx_cnt - rx0), 32'h0);

        // A normal write afterwards.
        i2c_start();
        i2c_byte(8'hA0, 1'b1, 8'h00, rb, ack);
        i2c_byte(8'h77, 1'b1, 8'h00, rb, ack2);
        check("rc_acks", 32'({ack, ack2}), 32'h0);
        check("rc_rx", 32'({rx_cnt - rx0, rx_last}), 32'h0177);
        i2c_stop();
        tick(20);

        // Five-cycle SDA glitches while SCL is high must not look like START or STOP.
        rx0 = rx_cnt;
        i2c_start();
        i2c_byte(8'hA0, 1'b1, 8'hC0, rb, ack);
        check("gl_addr_ack", 32'(ack), 32'h0);
        check("gl_status", 32'(status), 32'h03);
        i2c_byte(8'h33, 1'b1, 8'h00, rb, ack);
        check("gl_rx", 32'({rx_cnt - rx0, rx_last}), 32'h0133);
        i2c_stop();
        tick(20);

        check("strobe_overlap", 32'(overlap), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
